pll_phase_autotune: RTL and testbench

- Automatic SDRAM clock phase calibrator. Sits directly upstream of the dynamic-phase port of the SDRAM PLL and downstream of mem_tester.
- Steps the chip-clock phase through one full period and samples the pass/fail counters at each step. It then moves the PLL to the centre of the longest circular passing window.
- Replaces manual button tuning with a start-triggered sweep.

---
 rtl/pll_phase_autotune_pkg.sv | 39 +++
 rtl/pll_phase_stepper.sv | 76 +++++++
 rtl/pll_phase_autotune.sv | 237 +++++++++++++++++++++++
 tb/tb_pll_phase_autotune.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_autotune_pkg.sv
// ============================================================================
// Module      : pll_phase_autotune_pkg
// Description : Shared states, step modes and width helper for the SDRAM
//               clock phase autotuner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_phase_autotune_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SETTLE  = 4'd1,
        SNAP    = 4'd2,
        DWELL   = 4'd3,
        EVAL    = 4'd4,
        STEP_HI = 4'd5,
        STEP_LO = 4'd6,
        CENTER  = 4'd7,
        MOVE    = 4'd8,
        DONE    = 4'd9
    } state_t;

    // Where the FSM resumes once a single step has completed.
    typedef enum logic [1:0] {
        MODE_SWEEP = 2'd0,
        MODE_WRAP  = 2'd1,
        MODE_MOVE  = 2'd2
    } step_mode_t;

    localparam int c_snap_warmup = 16;

    function automatic int phase_width(input int steps);
        return $clog2(steps);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_phase_stepper.sv
// ============================================================================
// Module      : pll_phase_stepper
// Description : One PLL phase step per request: phasestep high then low for
//               C_pulse_cycles each; offset counter advances on the fall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_phase_stepper
    import pll_phase_autotune_pkg::*;
#(
    parameter int C_phase_steps  = 32,
    parameter int C_pulse_cycles = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   clear,
    input  logic                                   req,
    output logic                                   busy,
    output logic                                   ack,
    output logic                                   phasestep,
    output logic [phase_width(C_phase_steps)-1:0]  phase
);

    localparam int          c_w          = phase_width(C_phase_steps);
    localparam logic [15:0] c_pulse_last = 16'(C_pulse_cycles - 1);
    localparam logic [c_w-1:0] c_phase_one = c_w'(1);

    logic           r_busy;
    logic           r_ack;
    logic           r_phasestep;
    logic [15:0]    r_cnt;
    logic [c_w-1:0] r_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_phasestep <= 1'b0;
            r_cnt       <= '0;
            r_phase     <= '0;
        end else begin
            r_ack <= 1'b0;
            if (clear) begin
                r_phase <= '0;
            end
            if (!r_busy) begin
                if (req) begin
                    r_busy      <= 1'b1;
                    r_phasestep <= 1'b1;
                    r_cnt       <= '0;
                end
            end else if (r_cnt != c_pulse_last) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
                if (r_phasestep) begin
                    // The PLL acts on the falling strobe, so the offset moves here.
                    r_phasestep <= 1'b0;
                    r_phase     <= r_phase + c_phase_one;
                end else begin
                    r_busy <= 1'b0;
                    r_ack  <= 1'b1;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign ack       = r_ack;
    assign phasestep = r_phasestep;
    assign phase     = r_phase;

endmodule

`default_nettype wire

// File: rtl/pll_phase_autotune.sv
// ============================================================================
// Module      : pll_phase_autotune
// Description : Sweeps the SDRAM clock phase over one period, maps pass/fail
//               per offset and parks the PLL mid longest circular pass window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_phase_autotune
    import pll_phase_autotune_pkg::*;
#(
    parameter int C_phase_steps   = 32,
    parameter int C_pulse_cycles  = 4,
    parameter int C_settle_cycles = 256,
    parameter int C_dwell_cycles  = 1048576
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [31:0]              passcount,
    input  logic [31:0]              failcount,
    output logic                     phasedir,
    output logic                     phasestep,
    output logic                     tester_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     no_window,
    output logic [7:0]               phase,
    output logic [7:0]               best_phase,
    output logic [C_phase_steps-1:0] pass_map
);

    localparam int             c_w           = phase_width(C_phase_steps);
    localparam logic [31:0]    c_settle_last = 32'(C_settle_cycles - 1);
    localparam logic [31:0]    c_snap_last   = 32'(c_snap_warmup - 1);
    localparam logic [31:0]    c_dwell_last  = 32'(C_dwell_cycles - 1);
    localparam logic [c_w-1:0] c_phase_last  = c_w'(C_phase_steps - 1);
    localparam logic [c_w-1:0] c_one_w       = c_w'(1);
    localparam logic [c_w:0]   c_len_full    = (c_w + 1)'(C_phase_steps);
    localparam logic [c_w:0]   c_one_len     = (c_w + 1)'(1);
    localparam logic [c_w:0]   c_idx_last    = '1;

    state_t                 r_state;
    state_t                 w_state_nx;
    step_mode_t             r_mode;
    logic [31:0]            r_cnt;
    logic [31:0]            r_pass0;
    logic [31:0]            r_fail0;
    logic [C_phase_steps-1:0] r_pass_map;
    logic                   r_no_window;
    logic [c_w-1:0]         r_best_phase;
    logic [c_w-1:0]         r_move_left;
    logic [c_w:0]           r_idx;
    logic [c_w-1:0]         r_cur_start;
    logic [c_w:0]           r_cur_len;
    logic [c_w-1:0]         r_best_start;
    logic [c_w:0]           r_best_len;

    logic                   w_step_req;
    logic                   w_step_clear;
    logic                   w_step_busy;
    logic                   w_step_ack;
    logic [c_w-1:0]         w_phase;
    logic                   w_point_pass;
    logic                   w_scan_bit;
    logic [c_w-1:0]         w_cur_start_nx;
    logic [c_w:0]           w_cur_len_nx;
    logic [c_w-1:0]         w_best_start_nx;
    logic [c_w:0]           w_best_len_nx;
    logic [c_w-1:0]         w_best_phase;

    pll_phase_stepper #(
        .C_phase_steps  (C_phase_steps),
        .C_pulse_cycles (C_pulse_cycles)
    ) u_stepper (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_step_clear),
        .req       (w_step_req),
        .busy      (w_step_busy),
        .ack       (w_step_ack),
        .phasestep (phasestep),
        .phase     (w_phase)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_step_req   = 1'b0;
        w_step_clear = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_step_clear = 1'b1;
                    w_state_nx   = SETTLE;
                end
            end
            SETTLE:  if (r_cnt == c_settle_last) w_state_nx = SNAP;
            SNAP:    if (r_cnt == c_snap_last)   w_state_nx = DWELL;
            DWELL:   if (r_cnt == c_dwell_last)  w_state_nx = EVAL;
            EVAL:    w_state_nx = STEP_HI;
            STEP_HI: begin
                if (!w_step_busy) begin
                    w_step_req = 1'b1;
                    w_state_nx = STEP_LO;
                end
            end
            STEP_LO: begin
                if (w_step_ack) begin
                    unique case (r_mode)
                        MODE_WRAP: w_state_nx = CENTER;
                        MODE_MOVE: w_state_nx = MOVE;
                        default:   w_state_nx = SETTLE;
                    endcase
                end
            end
            CENTER:  if (r_idx == c_idx_last) w_state_nx = MOVE;
            MOVE:    w_state_nx = (r_move_left == '0) ? DONE : STEP_HI;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // A stalled tester (no new passes) is treated as failing.
    assign w_point_pass = (failcount == r_fail0) && (passcount != r_pass0);

    // Serial run-length scan over two laps of the map finds wrapping windows.
    always_comb begin
        w_scan_bit      = r_pass_map[r_idx[c_w-1:0]];
        w_cur_start_nx  = r_cur_start;
        w_cur_len_nx    = r_cur_len;
        w_best_start_nx = r_best_start;
        w_best_len_nx   = r_best_len;
        if (w_scan_bit) begin
            if (r_cur_len == '0) begin
                w_cur_start_nx = r_idx[c_w-1:0];
            end
            if (r_cur_len != c_len_full) begin
                w_cur_len_nx = r_cur_len + c_one_len;
            end
        end else begin
            w_cur_len_nx = '0;
        end
        if (w_cur_len_nx > r_best_len) begin
            w_best_len_nx   = w_cur_len_nx;
            w_best_start_nx = w_cur_start_nx;
        end
        if ((w_best_len_nx == '0) || (w_best_len_nx == c_len_full)) begin
            w_best_phase = '0;
        end else begin
            w_best_phase = w_best_start_nx + w_best_len_nx[c_w:1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode       <= MODE_SWEEP;
            r_cnt        <= '0;
            r_pass0      <= '0;
            r_fail0      <= '0;
            r_pass_map   <= '0;
            r_no_window  <= 1'b0;
            r_best_phase <= '0;
            r_move_left  <= '0;
            r_idx        <= '0;
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else begin
            r_cnt <= (w_state_nx != r_state) ? '0 : r_cnt + 32'd1;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pass_map  <= '0;
                        r_no_window <= 1'b0;
                    end
                end
                SNAP: begin
                    if (r_cnt == c_snap_last) begin
                        r_pass0 <= passcount;
                        r_fail0 <= failcount;
                    end
                end
                EVAL: begin
                    r_pass_map[w_phase] <= w_point_pass;
                    r_mode       <= (w_phase == c_phase_last) ? MODE_WRAP : MODE_SWEEP;
                    r_idx        <= '0;
                    r_cur_start  <= '0;
                    r_cur_len    <= '0;
                    r_best_start <= '0;
                    r_best_len   <= '0;
                end
                CENTER: begin
                    r_idx        <= r_idx + c_one_len;
                    r_cur_start  <= w_cur_start_nx;
                    r_cur_len    <= w_cur_len_nx;
                    r_best_start <= w_best_start_nx;
                    r_best_len   <= w_best_len_nx;
                    if (r_idx == c_idx_last) begin
                        r_no_window  <= (w_best_len_nx == '0);
                        r_best_phase <= w_best_phase;
                        r_move_left  <= w_best_phase;
                        r_mode       <= MODE_MOVE;
                    end
                end
                MOVE: begin
                    if (r_move_left != '0) begin
                        r_move_left <= r_move_left - c_one_w;
                    end
                end
                default: ;
            endcase
        end
    end

    assign phasedir    = 1'b0;
    assign tester_hold = (r_state == SETTLE)  || (r_state == STEP_HI) ||
                         (r_state == STEP_LO) || (r_state == CENTER)  ||
                         (r_state == MOVE);
    assign busy        = (r_state != IDLE) && (r_state != DONE);
    assign done        = (r_state == DONE);
    assign no_window   = r_no_window;
    assign phase       = {{(8 - c_w){1'b0}}, w_phase};
    assign best_phase  = {{(8 - c_w){1'b0}}, r_best_phase};
    assign pass_map    = r_pass_map;

endmodule

`default_nettype wire

// File: tb/tb_pll_phase_autotune.sv
// ============================================================================
// Module      : tb_pll_phase_autotune
// Description : Scoreboard bench for the phase autotuner with a PLL/tester model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_phase_autotune;

    typedef struct packed {
        logic [7:0] map;
        logic [7:0] best;
        logic       nw;
        logic [7:0] pulses;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] passcount = '0;
    logic [31:0] failcount = '0;
    logic        phasedir, phasestep, tester_hold, busy, done, no_window;
    logic [7:0]  phase, best_phase, pass_map;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   done_seen = 0;
    int   pulse_total = 0;
    int   pll_pos = 0;
    int   start_pos = 0;
    int   start_pulses = 0;
    logic [7:0] pass_set = '0;
    logic frozen = 1'b0;

    pll_phase_autotune #(
        .C_phase_steps   (8),
        .C_pulse_cycles  (2),
        .C_settle_cycles (8),
        .C_dwell_cycles  (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .passcount   (passcount),
        .failcount   (failcount),
        .phasedir    (phasedir),
        .phasestep   (phasestep),
        .tester_hold (tester_hold),
        .busy        (busy),
        .done        (done),
        .no_window   (no_window),
        .phase       (phase),
        .best_phase  (best_phase),
        .pass_map    (pass_map)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // PLL position tracker and mem_tester model.
    initial begin
        logic prev_ps;
        int   c4;
        int   off;
        prev_ps = 1'b0;
        c4 = 0;
        forever begin
            @(negedge clk);
            if (prev_ps && !phasestep) pll_pos = (pll_pos + 1) % 8;
            if (!prev_ps && phasestep) pulse_total++;
            prev_ps = phasestep;
            off = (pll_pos - start_pos + 8) % 8;
            if (!frozen) begin
                if (tester_hold) begin
                    passcount = '0;
                    failcount = '0;
                    c4 = 0;
                end else begin
                    c4++;
                    if (c4 % 4 == 0) begin
                        passcount = passcount + 32'd1;
                        if (!pass_set[off]) failcount = failcount + 32'd1;
                    end
                end
            end
        end
    end

    // Monitor: compares each done pulse against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no done");
                end else begin
                    e = exp_q.pop_front();
                    check("pass_map", int'(pass_map), int'(e.map));
                    check("best_phase", int'(best_phase), int'(e.best));
                    check("no_window", int'(no_window), int'(e.nw));
                    check("pulses", pulse_total - start_pulses, int'(e.pulses));
                    check("phase", int'(phase), int'(e.best));
                end
                done_seen++;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_phasedir"}, int'(phasedir), 0);
        check({tag, "_phasestep"}, int'(phasestep), 0);
        check({tag, "_tester_hold"}, int'(tester_hold), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_no_window"}, int'(no_window), 0);
        check({tag, "_phase"}, int'(phase), 0);
        check({tag, "_best_phase"}, int'(best_phase), 0);
        check({tag, "_pass_map"}, int'(pass_map), 0);
    endtask

    task automatic begin_sweep(input logic [7:0] ps, input logic frz,
                               input logic [7:0] em, input logic [7:0] eb,
                               input logic enw, input int ep);
        exp_t e;
        pass_set = ps;
        frozen   = frz;
        @(negedge clk);
        start_pos    = pll_pos;
        start_pulses = pulse_total;
        e.map    = em;
        e.best   = eb;
        e.nw     = enw;
        e.pulses = 8'(ep);
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_case(input logic [7:0] ps, input logic frz,
                            input logic [7:0] em, input logic [7:0] eb,
                            input logic enw, input int ep, input logic dup);
        int d0;
        int n;
        d0 = done_seen;
        begin_sweep(ps, frz, em, eb, enw, ep);
        if (dup) begin
            repeat (200) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (done_seen == d0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;

        run_case(8'h3C, 1'b0, 8'h3C, 8'd4, 1'b0, 12, 1'b0);
        run_case(8'hC3, 1'b0, 8'hC3, 8'd0, 1'b0, 8, 1'b0);
        run_case(8'h00, 1'b0, 8'h00, 8'd0, 1'b1, 8, 1'b0);
        run_case(8'hFF, 1'b1, 8'h00, 8'd0, 1'b1, 8, 1'b0);
        run_case(8'hFF, 1'b0, 8'hFF, 8'd0, 1'b0, 8, 1'b0);
        run_case(8'h22, 1'b0, 8'h22, 8'd1, 1'b0, 9, 1'b0);

        // Abort a sweep while dwelling at offset 3.
        begin_sweep(8'h3C, 1'b0, 8'h3C, 8'd4, 1'b0, 12);
        n = 0;
        while (!(phase == 8'd3 && !tester_hold) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("reach_offset3", int'(phase == 8'd3 && !tester_hold), 1);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("abort");
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_case(8'h3C, 1'b0, 8'h3C, 8'd4, 1'b0, 12, 1'b1);
        repeat (20) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        check("total_done_pulses", done_seen, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
